// File: rtl/modn_sync_cascade_counter.sv
`default_nettype none
// ============================================================================
// Module      : modn_sync_cascade_counter
// Description : Fully synchronous mod-N counter made of DIGITS cascaded digit
//               stages. Every digit counts 0..MODULUS-1. Supports up/down
//               counting, count enable, synchronous clear, range-checked
//               parallel load, a combinational terminal-count output for
//               chaining further instances, and registered wrap / load-error
//               pulses. All state is clocked by clk only.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DIGITS   number of cascaded digit stages (1..8)
//   MODULUS  count modulus of every digit (2..2**DW)
//   DW       bit width of one digit field (2**DW >= MODULUS)
// Ports:
//   clk       in   1          rising-edge clock for all state
//   reset     in   1          asynchronous, active-high; clears all state
//   en        in   1          count enable, one step per enabled cycle
//   up        in   1          1 = increment, 0 = decrement
//   clear     in   1          synchronous clear (highest priority)
//   load      in   1          synchronous parallel load of load_val
//   load_val  in   DIGITS*DW  load value, digit k at [k*DW +: DW]
//   count     out  DIGITS*DW  current count, same packing as load_val
//   tc        out  1          en & (counter at all-max when up / all-zero
//                             when down); drives en of a following instance
//   wrap      out  1          one-cycle pulse: previous cycle wrapped fully
//   load_err  out  1          one-cycle pulse: previous load had at least
//                             one out-of-range digit
// ============================================================================
module modn_sync_cascade_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10,
  parameter int DW      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 up,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 wrap,
  output logic                 load_err
);

  // Digit-wide constants; all digit arithmetic stays DW bits wide.
  localparam logic [DW-1:0] c_MAX_DIGIT = DW'(MODULUS - 1);
  localparam logic [DW-1:0] c_ONE       = DW'(1);
  localparam logic [DW-1:0] c_ZERO      = '0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DIGITS*DW-1:0] r_count;
  logic                 r_wrap;
  logic                 r_load_err;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  // w_step[k] is the carry/borrow into digit k: digit k moves on an enabled
  // cycle when every lower digit sits at its terminal value for the current
  // direction. w_step[DIGITS] therefore means the whole counter is terminal.
  logic [DIGITS:0]      w_step;
  logic [DIGITS-1:0]    w_at_max;
  logic [DIGITS-1:0]    w_at_zero;
  logic [DIGITS-1:0]    w_ld_bad;
  logic [DIGITS*DW-1:0] w_cnt_stepped;
  logic [DIGITS*DW-1:0] w_ld_sane;
  logic                 w_all_term;

  logic [DIGITS*DW-1:0] w_count_nxt;
  logic                 w_wrap_nxt;
  logic                 w_load_err_nxt;

  // Digit 0 always steps when the counter is enabled.
  assign w_step[0] = 1'b1;

  // --------------------------------------------------------------------------
  // Per-digit datapath: step value, carry/borrow chain, load sanitising
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic [DW-1:0] w_cur;
      logic [DW-1:0] w_inc;
      logic [DW-1:0] w_dec;
      logic [DW-1:0] w_ld;

      assign w_cur        = r_count[k*DW +: DW];
      assign w_at_max[k]  = (w_cur == c_MAX_DIGIT);
      assign w_at_zero[k] = (w_cur == c_ZERO);

      // Wrap is selected before the +1/-1 result could leave 0..MODULUS-1,
      // so no intermediate value ever exceeds the digit range.
      assign w_inc = w_at_max[k]  ? c_ZERO      : (w_cur + c_ONE);
      assign w_dec = w_at_zero[k] ? c_MAX_DIGIT : (w_cur - c_ONE);

      assign w_step[k+1] = w_step[k] & (up ? w_at_max[k] : w_at_zero[k]);

      assign w_cnt_stepped[k*DW +: DW] = w_step[k] ? (up ? w_inc : w_dec) : w_cur;

      // Out-of-range load digits are replaced by 0 so a digit can never hold
      // a value >= MODULUS, whatever is presented on load_val.
      assign w_ld                  = load_val[k*DW +: DW];
      assign w_ld_bad[k]           = (w_ld > c_MAX_DIGIT);
      assign w_ld_sane[k*DW +: DW] = w_ld_bad[k] ? c_ZERO : w_ld;
    end
  endgenerate

  assign w_all_term = w_step[DIGITS];

  // --------------------------------------------------------------------------
  // Next-state selection: clear > load > en
  // --------------------------------------------------------------------------
  always_comb begin
    w_count_nxt    = r_count;
    w_wrap_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
    if (clear) begin
      w_count_nxt = '0;
    end else if (load) begin
      w_count_nxt    = w_ld_sane;
      w_load_err_nxt = |w_ld_bad;
    end else if (en) begin
      w_count_nxt = w_cnt_stepped;
      // A full rollover happens exactly when the carry/borrow propagates out
      // of the top digit.
      w_wrap_nxt  = w_all_term;
    end
  end

  // --------------------------------------------------------------------------
  // State register, asynchronous active-high reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign count    = r_count;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

  // tc deliberately ignores clear/load: it reflects only the enable and the
  // present count, so a chained instance sees a stable enable this cycle.
  assign tc = en & w_all_term;

endmodule
`default_nettype wire
